// File: rtl/lab2_proc_test_mem_responder.sv
// lab2_proc_test_mem_responder: val/rdy single-port word memory with subword access and programmable response latency
module lab2_proc_test_mem_responder #(
    parameter int p_mem_nwords = 1024,
    parameter int p_latency    = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        reqstream_val,
    output logic        reqstream_rdy,
    input  logic [76:0] reqstream_msg,
    output logic        respstream_val,
    input  logic        respstream_rdy,
    output logic [46:0] respstream_msg
);
    localparam int IW = $clog2(p_mem_nwords);
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    state_t state;
    logic [3:0] cnt;
    logic [31:0] mem [p_mem_nwords];
    logic [2:0] req_type;
    logic [7:0] req_opq;
    logic [31:0] req_addr, req_data;
    logic [1:0] req_len, off;
    logic [IW-1:0] idx;
    logic [3:0] lim, be;
    logic [31:0] mask, wdata, rdata;
    logic accept, is_wr, is_bad;
    assign {req_type, req_opq, req_addr, req_len, req_data} = reqstream_msg;
    assign accept = reqstream_val && reqstream_rdy;
    assign is_wr  = req_type == 3'd1 || req_type == 3'd2;
    assign is_bad = req_type > 3'd2;
    // Byte lanes run from the offset up to the word boundary; bytes past it are dropped.
    always_comb begin
        idx  = IW'(req_addr >> 2);
        off  = req_addr[1:0];
        lim  = 4'(off) + (req_len == 2'd0 ? 4'd4 : 4'(req_len));
        be   = '0;
        mask = '0;
        for (int i = 0; i < 4; i++) begin
            be[i] = 4'(i) >= 4'(off) && 4'(i) < lim;
            mask[8*i +: 8] = {8{be[i]}};
        end
        wdata = req_data << {off, 3'b000};
        rdata = (mem[idx] & mask) >> {off, 3'b000};
    end
    always_ff @(posedge clk) begin
        if (accept && is_wr)
            for (int i = 0; i < 4; i++)
                if (be[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            cnt            <= '0;
            reqstream_rdy  <= 1'b0;
            respstream_val <= 1'b0;
            respstream_msg <= '0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    reqstream_rdy  <= 1'b0;
                    respstream_msg <= {req_type, req_opq, is_bad ? 2'b11 : 2'b00, req_len,
                                       req_type == 3'd0 ? rdata : 32'd0};
                    if (p_latency > 0) begin
                        state <= WAIT;
                        cnt   <= 4'(p_latency);
                    end else begin
                        state          <= RESP;
                        respstream_val <= 1'b1;
                    end
                end else reqstream_rdy <= 1'b1;
                WAIT: if (cnt == 4'd1) begin
                    state          <= RESP;
                    respstream_val <= 1'b1;
                end else cnt <= cnt - 4'd1;
                RESP: if (respstream_rdy) begin
                    state          <= IDLE;
                    respstream_val <= 1'b0;
                    reqstream_rdy  <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
